// File: rtl/fifo_word_packer.sv
// Read-domain byte-to-word packer: pops an async FIFO, packs BYTES little-endian lanes, flushes partial words on idle timeout.
// Optional per-lane parity output enabled by defining FIFO_WORD_PACKER_PARITY_EN.
module fifo_word_packer #(
  parameter int DATA_W  = 8,
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst,
  input  logic                      fifo_empty,
  input  logic [DATA_W-1:0]         fifo_data,
  output logic                      fifo_rd_en,
  output logic [DATA_W*BYTES-1:0]   m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(BYTES):0]    m_bytes,
  output logic                      m_partial
`ifdef FIFO_WORD_PACKER_PARITY_EN
  ,
  output logic [BYTES-1:0]          m_parity
`endif
);

  localparam int CNT_W = $clog2(BYTES) + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(BYTES);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] OUT  = 1'b1;

  logic [0:0]              state;
  logic [CNT_W-1:0]        issued;
  logic [CNT_W-1:0]        recv;
  logic [TMR_W-1:0]        timer;
  logic                    vld_p1;
  logic [DATA_W*BYTES-1:0] word_nxt;
  logic                    armed;
  logic                    expire;
  logic                    last_cap;

  function automatic logic [DATA_W*BYTES-1:0] insert_lane(
    input logic [DATA_W*BYTES-1:0] w,
    input logic [CNT_W-1:0]        lane,
    input logic [DATA_W-1:0]       b
  );
    insert_lane = w;
    for (int i = 0; i < BYTES; i++)
      if (lane == CNT_W'(i)) insert_lane[i*DATA_W +: DATA_W] = b;
  endfunction

`ifdef FIFO_WORD_PACKER_PARITY_EN
  function automatic logic [BYTES-1:0] lane_parity(input logic [DATA_W*BYTES-1:0] w);
    lane_parity = '0;
    for (int i = 0; i < BYTES; i++)
      lane_parity[i] = ^w[i*DATA_W +: DATA_W];
  endfunction
`endif

  // Timer only runs once every requested byte has landed; an expiring timer blocks a same-cycle pop.
  always_comb begin
    armed      = (TIMEOUT != 0) && (state == FILL) && (recv != '0) && (issued == recv);
    expire     = armed && (timer == TMO_LAST);
    fifo_rd_en = ~rd_rst & (state == FILL) & ~fifo_empty & (issued < FULL) & ~expire;
    last_cap   = vld_p1 && (recv == FULL - CNT_W'(1));
    word_nxt   = insert_lane(m_data, recv, fifo_data);
  end

  // Stage p1: byte popped last cycle is on fifo_data and lands in lane recv.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state     <= FILL;
      issued    <= '0;
      recv      <= '0;
      timer     <= '0;
      vld_p1    <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_bytes   <= '0;
      m_partial <= 1'b0;
`ifdef FIFO_WORD_PACKER_PARITY_EN
      m_parity  <= '0;
`endif
    end else begin
      vld_p1 <= fifo_rd_en;
      if (state == FILL) begin
        if (fifo_rd_en) issued <= issued + CNT_W'(1);
        timer <= (armed && fifo_empty && !expire) ? timer + TMR_W'(1) : '0;
        if (vld_p1) begin
          recv   <= recv + CNT_W'(1);
          m_data <= word_nxt;
`ifdef FIFO_WORD_PACKER_PARITY_EN
          m_parity <= lane_parity(word_nxt);
`endif
        end
        if (last_cap) begin
          state     <= OUT;
          m_valid   <= 1'b1;
          m_bytes   <= FULL;
          m_partial <= 1'b0;
        end else if (expire) begin
          state     <= OUT;
          m_valid   <= 1'b1;
          m_bytes   <= recv;
          m_partial <= 1'b1;
        end
      end else if (m_ready) begin
        state     <= FILL;
        issued    <= '0;
        recv      <= '0;
        timer     <= '0;
        m_data    <= '0;
        m_valid   <= 1'b0;
        m_bytes   <= '0;
        m_partial <= 1'b0;
`ifdef FIFO_WORD_PACKER_PARITY_EN
        m_parity  <= '0;
`endif
      end
    end
  end

endmodule
